// File: rtl/pcie_egress_arbiter_pkg.sv
// Shared types and constants for the PCIe egress arbiter.
// Requester indices double as the egress FIFO-mux select.
package pcie_egress_arbiter_pkg;

  localparam logic [1:0] EGRESS_REQ_CFG  = 2'd0;
  localparam logic [1:0] EGRESS_REQ_DATA = 2'd1;
  localparam logic [1:0] EGRESS_REQ_CMPL = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_WAIT_FC,
    ST_ACTIVE,
    ST_RELEASE
  } egress_state_e;

  typedef struct packed {
    logic [7:0]  command;
    logic [13:0] flags;
    logic [31:0] address;
    logic [15:0] requester_id;
    logic [7:0]  tag;
  } egress_hdr_t;

endpackage

// File: rtl/egress_rr_select.sv
// Combinational winner select: completion has strict priority,
// cfg/data share round-robin starting at the rr pointer.
module egress_rr_select
  import pcie_egress_arbiter_pkg::*;
(
  input  logic [2:0] i_req,
  input  logic       i_rr_ptr,
  output logic       o_valid,
  output logic [2:0] o_onehot,
  output logic [1:0] o_idx
);

  logic pick_cmpl;
  logic pick_cfg;
  logic pick_data;

  assign pick_cmpl = i_req[2];
  assign pick_cfg  = !i_req[2] && i_req[0] &&
                     (!i_req[1] || !i_rr_ptr);
  assign pick_data = !i_req[2] && i_req[1] &&
                     (!i_req[0] || i_rr_ptr);
  assign o_valid   = |i_req;

  always_comb begin
    o_onehot = 3'b000;
    o_idx    = EGRESS_REQ_CFG;
    unique case (1'b1)
      pick_cmpl: begin
        o_onehot = 3'b100;
        o_idx    = EGRESS_REQ_CMPL;
      end
      pick_data: begin
        o_onehot = 3'b010;
        o_idx    = EGRESS_REQ_DATA;
      end
      pick_cfg: begin
        o_onehot = 3'b001;
        o_idx    = EGRESS_REQ_CFG;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pcie_egress_arbiter.sv
// Arbitrates the single egress TLP engine among cfg, DMA data
// and completion requesters; holds enable until engine finishes.
module pcie_egress_arbiter
  import pcie_egress_arbiter_pkg::*;
#(
  parameter int TIMEOUT_WIDTH = 16,
  parameter int NUM_REQ       = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_cmd_rst_stb,
  input  logic [NUM_REQ-1:0]    i_req,
  input  logic [8*NUM_REQ-1:0]  i_tlp_command,
  input  logic [14*NUM_REQ-1:0] i_tlp_flags,
  input  logic [32*NUM_REQ-1:0] i_tlp_address,
  input  logic [16*NUM_REQ-1:0] i_tlp_requester_id,
  input  logic [8*NUM_REQ-1:0]  i_tlp_tag,
  output logic [NUM_REQ-1:0]    o_grant,
  output logic [NUM_REQ-1:0]    o_done,
  output logic                  o_error,
  input  logic                  i_pcie_fc_ready,
  output logic                  o_egress_enable,
  input  logic                  i_egress_finished,
  output logic [7:0]            o_egress_tlp_command,
  output logic [13:0]           o_egress_tlp_flags,
  output logic [31:0]           o_egress_tlp_address,
  output logic [15:0]           o_egress_tlp_requester_id,
  output logic [7:0]            o_egress_tlp_tag,
  output logic [1:0]            o_egress_fifo_select,
  output logic                  o_busy,
  output logic [7:0]            o_timeout_count
);

  egress_state_e            state_q, state_d;
  logic                     rr_q, rr_d;
  logic [2:0]               grant_q, grant_d;
  logic [2:0]               done_q, done_d;
  logic                     err_q, err_d;
  logic                     en_q, en_d;
  egress_hdr_t              hdr_q, hdr_d;
  logic [1:0]               sel_q, sel_d;
  logic [TIMEOUT_WIDTH-1:0] wd_q, wd_d;
  logic [TIMEOUT_WIDTH-1:0] wd_inc;
  logic [7:0]               tcnt_q, tcnt_d;

  logic        win_valid;
  logic [2:0]  win_onehot;
  logic [1:0]  win_idx;
  egress_hdr_t win_hdr;

  egress_rr_select u_sel (
    .i_req    (i_req),
    .i_rr_ptr (rr_q),
    .o_valid  (win_valid),
    .o_onehot (win_onehot),
    .o_idx    (win_idx)
  );

  always_comb begin
    win_hdr.command      = i_tlp_command[win_idx*8 +: 8];
    win_hdr.flags        = i_tlp_flags[win_idx*14 +: 14];
    win_hdr.address      = i_tlp_address[win_idx*32 +: 32];
    win_hdr.requester_id = i_tlp_requester_id[win_idx*16 +: 16];
    win_hdr.tag          = i_tlp_tag[win_idx*8 +: 8];
  end

  assign wd_inc = wd_q + 1'b1;

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    done_d  = 3'b000;
    err_d   = err_q;
    en_d    = en_q;
    hdr_d   = hdr_q;
    sel_d   = sel_q;
    wd_d    = wd_q;
    tcnt_d  = tcnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (win_valid) begin
          state_d = ST_GRANT;
          grant_d = win_onehot;
          sel_d   = win_idx;
          hdr_d   = win_hdr;
        end
      end
      ST_GRANT: state_d = ST_WAIT_FC;
      ST_WAIT_FC: begin
        if (i_pcie_fc_ready) begin
          state_d = ST_ACTIVE;
          en_d    = 1'b1;
          wd_d    = '0;
        end
      end
      ST_ACTIVE: begin
        wd_d = wd_inc;
        // finished beats a coincident watchdog terminal count
        if (i_egress_finished) begin
          state_d = ST_RELEASE;
          en_d    = 1'b0;
          done_d  = grant_q;
          err_d   = 1'b0;
        end else if (wd_inc == {TIMEOUT_WIDTH{1'b1}}) begin
          state_d = ST_RELEASE;
          en_d    = 1'b0;
          done_d  = grant_q;
          err_d   = 1'b1;
          if (tcnt_q != 8'hFF) tcnt_d = tcnt_q + 8'd1;
        end
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
        if (grant_q[0]) rr_d = 1'b1;
        else if (grant_q[1]) rr_d = 1'b0;
        grant_d = 3'b000;
        err_d   = 1'b0;
        hdr_d   = '0;
        sel_d   = 2'd0;
        wd_d    = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || i_cmd_rst_stb) begin
      state_q <= ST_IDLE;
      rr_q    <= 1'b0;
      grant_q <= 3'b000;
      done_q  <= 3'b000;
      err_q   <= 1'b0;
      en_q    <= 1'b0;
      hdr_q   <= '0;
      sel_q   <= 2'd0;
      wd_q    <= '0;
      tcnt_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      err_q   <= err_d;
      en_q    <= en_d;
      hdr_q   <= hdr_d;
      sel_q   <= sel_d;
      wd_q    <= wd_d;
      tcnt_q  <= tcnt_d;
    end
  end

  assign o_grant                   = grant_q;
  assign o_done                    = done_q;
  assign o_error                   = err_q;
  assign o_egress_enable           = en_q;
  assign o_egress_tlp_command      = hdr_q.command;
  assign o_egress_tlp_flags        = hdr_q.flags;
  assign o_egress_tlp_address      = hdr_q.address;
  assign o_egress_tlp_requester_id = hdr_q.requester_id;
  assign o_egress_tlp_tag          = hdr_q.tag;
  assign o_egress_fifo_select      = sel_q;
  assign o_busy                    = (state_q != ST_IDLE);
  assign o_timeout_count           = tcnt_q;

endmodule

// File: tb/tb_pcie_egress_arbiter.sv
// Directed bench for pcie_egress_arbiter with a 4-bit watchdog.
// Inputs change and outputs are sampled 1ns after posedge.
module tb_pcie_egress_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_cmd_rst_stb;
  logic [2:0]  i_req;
  logic [23:0] i_tlp_command;
  logic [41:0] i_tlp_flags;
  logic [95:0] i_tlp_address;
  logic [47:0] i_tlp_requester_id;
  logic [23:0] i_tlp_tag;
  logic [2:0]  o_grant;
  logic [2:0]  o_done;
  logic        o_error;
  logic        i_pcie_fc_ready;
  logic        o_egress_enable;
  logic        i_egress_finished;
  logic [7:0]  o_egress_tlp_command;
  logic [13:0] o_egress_tlp_flags;
  logic [31:0] o_egress_tlp_address;
  logic [15:0] o_egress_tlp_requester_id;
  logic [7:0]  o_egress_tlp_tag;
  logic [1:0]  o_egress_fifo_select;
  logic        o_busy;
  logic [7:0]  o_timeout_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pcie_egress_arbiter #(.TIMEOUT_WIDTH(4), .NUM_REQ(3)) dut (
    .clk                       (clk),
    .rst                       (rst),
    .i_cmd_rst_stb             (i_cmd_rst_stb),
    .i_req                     (i_req),
    .i_tlp_command             (i_tlp_command),
    .i_tlp_flags               (i_tlp_flags),
    .i_tlp_address             (i_tlp_address),
    .i_tlp_requester_id        (i_tlp_requester_id),
    .i_tlp_tag                 (i_tlp_tag),
    .o_grant                   (o_grant),
    .o_done                    (o_done),
    .o_error                   (o_error),
    .i_pcie_fc_ready           (i_pcie_fc_ready),
    .o_egress_enable           (o_egress_enable),
    .i_egress_finished         (i_egress_finished),
    .o_egress_tlp_command      (o_egress_tlp_command),
    .o_egress_tlp_flags        (o_egress_tlp_flags),
    .o_egress_tlp_address      (o_egress_tlp_address),
    .o_egress_tlp_requester_id (o_egress_tlp_requester_id),
    .o_egress_tlp_tag          (o_egress_tlp_tag),
    .o_egress_fifo_select      (o_egress_fifo_select),
    .o_busy                    (o_busy),
    .o_timeout_count           (o_timeout_count)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_hdrs;
    i_tlp_command      = {8'h4A, 8'h60, 8'h40};
    i_tlp_flags        = {14'h1555, 14'h2AAA, 14'h0123};
    i_tlp_address      = {32'hDEAD_BEEF, 32'h2000_0080,
                          32'h1000_0040};
    i_tlp_requester_id = {16'h0300, 16'h0200, 16'h0100};
    i_tlp_tag          = {8'h22, 8'h11, 8'h05};
  endtask

  task automatic do_reset;
    rst = 1'b1;
    i_req = 3'b000;
    i_egress_finished = 1'b0;
    tick;
    tick;
    rst = 1'b0;
  endtask

  // one finished-terminated transfer; caller already drives i_req
  task automatic xfer(input logic [2:0] req_after,
                      output logic [2:0] g,
                      output logic [1:0] s,
                      output logic [2:0] d,
                      output logic e);
    tick;
    g = o_grant;
    s = o_egress_fifo_select;
    tick;
    tick;
    i_egress_finished = 1'b1;
    tick;
    d = o_done;
    e = o_error;
    i_egress_finished = 1'b0;
    i_req = req_after;
    tick;
  endtask

  task automatic test_reset;
    i_cmd_rst_stb = 1'b0;
    i_pcie_fc_ready = 1'b1;
    set_hdrs;
    do_reset;
    checks++;
    if ({o_grant, o_done, o_error, o_egress_enable, o_busy,
         o_egress_fifo_select, o_timeout_count} !== 17'd0) begin
      failures++;
      $display("FAIL reset_ctrl got grant=%b done=%b en=%b busy=%b tc=%0d exp 0",
               o_grant, o_done, o_egress_enable, o_busy,
               o_timeout_count);
    end
    checks++;
    if ({o_egress_tlp_command, o_egress_tlp_address,
         o_egress_tlp_tag} !== 48'd0) begin
      failures++;
      $display("FAIL reset_hdr got cmd=%h addr=%h exp 0",
               o_egress_tlp_command, o_egress_tlp_address);
    end
  endtask

  task automatic test_single;
    do_reset;
    i_req = 3'b001;
    tick;
    checks++;
    if (o_grant !== 3'b001 || o_busy !== 1'b1 ||
        o_egress_enable !== 1'b0) begin
      failures++;
      $display("FAIL single_grant got grant=%b busy=%b en=%b exp 001 1 0",
               o_grant, o_busy, o_egress_enable);
    end
    checks++;
    if (o_egress_tlp_command !== 8'h40 ||
        o_egress_tlp_address !== 32'h1000_0040 ||
        o_egress_tlp_flags !== 14'h0123 ||
        o_egress_tlp_requester_id !== 16'h0100 ||
        o_egress_tlp_tag !== 8'h05 ||
        o_egress_fifo_select !== 2'd0) begin
      failures++;
      $display("FAIL single_hdr got cmd=%h addr=%h fl=%h rid=%h tag=%h sel=%0d",
               o_egress_tlp_command, o_egress_tlp_address,
               o_egress_tlp_flags, o_egress_tlp_requester_id,
               o_egress_tlp_tag, o_egress_fifo_select);
    end
    tick;
    checks++;
    if (o_egress_enable !== 1'b0) begin
      failures++;
      $display("FAIL single_en_early got %b exp 0", o_egress_enable);
    end
    tick;
    checks++;
    if (o_egress_enable !== 1'b1) begin
      failures++;
      $display("FAIL single_latency got en=%b exp 1", o_egress_enable);
    end
    for (int i = 0; i < 5; i++) begin
      tick;
      checks++;
      if (o_egress_enable !== 1'b1 || o_done !== 3'b000) begin
        failures++;
        $display("FAIL single_hold got en=%b done=%b exp 1 000",
                 o_egress_enable, o_done);
      end
    end
    i_egress_finished = 1'b1;
    tick;
    i_egress_finished = 1'b0;
    i_req = 3'b000;
    checks++;
    if (o_done !== 3'b001 || o_error !== 1'b0 ||
        o_egress_enable !== 1'b0 || o_grant !== 3'b001) begin
      failures++;
      $display("FAIL single_done got done=%b err=%b en=%b grant=%b",
               o_done, o_error, o_egress_enable, o_grant);
    end
    tick;
    checks++;
    if (o_busy !== 1'b0 || o_done !== 3'b000 ||
        o_grant !== 3'b000 || o_egress_tlp_address !== 32'd0) begin
      failures++;
      $display("FAIL single_idle got busy=%b done=%b grant=%b addr=%h",
               o_busy, o_done, o_grant, o_egress_tlp_address);
    end
  endtask

  task automatic test_priority;
    logic [2:0] g;
    logic [2:0] d;
    logic [1:0] s;
    logic       e;
    logic [2:0] exp_g [3];
    logic [2:0] after [3];
    exp_g = '{3'b100, 3'b001, 3'b010};
    after = '{3'b011, 3'b010, 3'b000};
    do_reset;
    i_req = 3'b111;
    for (int i = 0; i < 3; i++) begin
      xfer(after[i], g, s, d, e);
      checks++;
      if (g !== exp_g[i] || d !== exp_g[i] || e !== 1'b0) begin
        failures++;
        $display("FAIL prio_%0d got grant=%b done=%b err=%b exp %b",
                 i, g, d, e, exp_g[i]);
      end
    end
    checks++;
    if (o_busy !== 1'b0) begin
      failures++;
      $display("FAIL prio_idle got busy=%b exp 0", o_busy);
    end
    do_reset;
    i_req = 3'b011;
    for (int i = 0; i < 4; i++) begin
      xfer(3'b011, g, s, d, e);
      checks++;
      if (g !== ((i % 2 == 0) ? 3'b001 : 3'b010) ||
          s !== ((i % 2 == 0) ? 2'd0 : 2'd1)) begin
        failures++;
        $display("FAIL rr_alt_%0d got grant=%b sel=%0d", i, g, s);
      end
    end
    i_req = 3'b000;
    tick;
    tick;
  endtask

  task automatic test_fc_stall;
    do_reset;
    i_pcie_fc_ready = 1'b0;
    i_req = 3'b001;
    tick;
    tick;
    i_egress_finished = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick;
      i_egress_finished = 1'b0;
      checks++;
      if (o_egress_enable !== 1'b0 || o_done !== 3'b000 ||
          o_busy !== 1'b1 || o_timeout_count !== 8'd0) begin
        failures++;
        $display("FAIL fc_stall_%0d got en=%b done=%b busy=%b tc=%0d",
                 i, o_egress_enable, o_done, o_busy, o_timeout_count);
      end
    end
    i_pcie_fc_ready = 1'b1;
    tick;
    checks++;
    if (o_egress_enable !== 1'b1) begin
      failures++;
      $display("FAIL fc_release got en=%b exp 1", o_egress_enable);
    end
    i_egress_finished = 1'b1;
    tick;
    i_egress_finished = 1'b0;
    i_req = 3'b000;
    checks++;
    if (o_done !== 3'b001 || o_error !== 1'b0) begin
      failures++;
      $display("FAIL fc_done got done=%b err=%b exp 001 0",
               o_done, o_error);
    end
    tick;
  endtask

  task automatic test_watchdog;
    int n;
    do_reset;
    i_req = 3'b001;
    tick;
    tick;
    tick;
    n = 0;
    while (o_egress_enable === 1'b1 && n < 40) begin
      n++;
      tick;
    end
    checks++;
    if (n !== 15) begin
      failures++;
      $display("FAIL wd_active_cycles got %0d exp 15", n);
    end
    checks++;
    if (o_done !== 3'b001 || o_error !== 1'b1 ||
        o_timeout_count !== 8'd1) begin
      failures++;
      $display("FAIL wd_done got done=%b err=%b tc=%0d exp 001 1 1",
               o_done, o_error, o_timeout_count);
    end
    i_req = 3'b000;
    tick;
    for (int k = 2; k <= 300; k++) begin
      i_req = 3'b001;
      n = 0;
      while (o_done === 3'b000 && n < 40) begin
        n++;
        tick;
      end
      checks++;
      if (o_done !== 3'b001 || o_error !== 1'b1 ||
          o_timeout_count !== ((k > 255) ? 8'd255 : 8'(k))) begin
        failures++;
        $display("FAIL wd_sat_%0d got done=%b err=%b tc=%0d",
                 k, o_done, o_error, o_timeout_count);
      end
      i_req = 3'b000;
      tick;
    end
  endtask

  task automatic test_reset_mid;
    logic [2:0] g;
    logic [2:0] d;
    logic [1:0] s;
    logic       e;
    i_req = 3'b011;
    tick;
    checks++;
    if (o_grant !== 3'b010) begin
      failures++;
      $display("FAIL mid_pre_grant got %b exp 010", o_grant);
    end
    tick;
    tick;
    i_cmd_rst_stb = 1'b1;
    tick;
    i_cmd_rst_stb = 1'b0;
    checks++;
    if (o_egress_enable !== 1'b0 || o_grant !== 3'b000 ||
        o_done !== 3'b000 || o_busy !== 1'b0 ||
        o_timeout_count !== 8'd0) begin
      failures++;
      $display("FAIL mid_reset got en=%b grant=%b done=%b busy=%b tc=%0d",
               o_egress_enable, o_grant, o_done, o_busy,
               o_timeout_count);
    end
    xfer(3'b000, g, s, d, e);
    checks++;
    if (g !== 3'b001 || d !== 3'b001) begin
      failures++;
      $display("FAIL mid_rr_restart got grant=%b done=%b exp 001",
               g, d);
    end
    tick;
  endtask

  task automatic test_hdr_stable;
    do_reset;
    i_req = 3'b100;
    tick;
    i_tlp_address = 96'h0123_4567_89AB_CDEF_5555_AAAA;
    i_tlp_command = 24'hFFFFFF;
    tick;
    tick;
    checks++;
    if (o_egress_tlp_address !== 32'hDEAD_BEEF ||
        o_egress_tlp_command !== 8'h4A ||
        o_egress_fifo_select !== 2'd2 ||
        o_egress_enable !== 1'b1) begin
      failures++;
      $display("FAIL hdr_stable got addr=%h cmd=%h sel=%0d en=%b",
               o_egress_tlp_address, o_egress_tlp_command,
               o_egress_fifo_select, o_egress_enable);
    end
    i_egress_finished = 1'b1;
    tick;
    i_egress_finished = 1'b0;
    i_req = 3'b000;
    checks++;
    if (o_done !== 3'b100 || o_egress_tlp_address !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL hdr_done got done=%b addr=%h", o_done,
               o_egress_tlp_address);
    end
    tick;
  endtask

  initial begin
    test_reset;
    test_single;
    test_priority;
    test_fc_stall;
    test_watchdog;
    test_reset_mid;
    test_hdr_stable;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
